// File: rtl/chess_clock_ctrl_if.sv
// Chess clock control/status bundle: game-control inputs toward the
// clock controller and remaining-time/flag status back to the display side.
interface chess_clock_ctrl_if #(
   parameter int TIME_W = 12,
   parameter int INC_W  = 6
);
   logic              load;
   logic [TIME_W-1:0] start_time;
   logic [INC_W-1:0]  increment;
   logic              start;
   logic              move_done;
   logic              pause;
   logic [TIME_W-1:0] white_time;
   logic [TIME_W-1:0] black_time;
   logic              turn;
   logic              running;
   logic              flag;
   logic              flag_player;

   modport master (
      output load, start_time, increment,
      output start, move_done, pause,
      input  white_time, black_time, turn,
      input  running, flag, flag_player
   );

   modport slave (
      input  load, start_time, increment,
      input  start, move_done, pause,
      output white_time, black_time, turn,
      output running, flag, flag_player
   );
endinterface

// File: rtl/chess_clock_ctrl.sv
// Two-player chess clock: shared one-second prescaler, per-player
// countdown with Fischer increment, and time-out flag.
module chess_clock_ctrl #(
   parameter int TICKS_PER_SEC = 50000000,
   parameter int TIME_W        = 12,
   parameter int INC_W         = 6
) (
   input logic                 clock,
   input logic                 clr,
   chess_clock_ctrl_if.slave   bus
);
   localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
   localparam int SW = TIME_W + 1;
   localparam logic [PW-1:0] TERM = PW'(TICKS_PER_SEC - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FLAG = 2'd2
   } state_t;

   state_t            r_state;
   logic [PW-1:0]     r_presc;
   logic [TIME_W-1:0] r_white;
   logic [TIME_W-1:0] r_black;
   logic              r_turn;
   logic              r_running;
   logic              r_flag;
   logic              r_flag_player;

   logic [TIME_W-1:0] w_active;
   logic              w_tick;
   logic [TIME_W-1:0] w_dec;
   logic [SW-1:0]     w_sum;
   logic [TIME_W-1:0] w_sat;
   logic              w_zero;

   assign w_active = r_turn ? r_black : r_white;
   assign w_tick   = (r_presc == TERM);
   // RUN never holds a zero active time, so the decrement cannot wrap
   assign w_dec    = w_tick ? (w_active - 1'b1) : w_active;
   assign w_zero   = w_tick && (w_dec == '0);
   assign w_sum    = {1'b0, w_dec} + SW'(bus.increment);
   assign w_sat    = w_sum[TIME_W] ? {TIME_W{1'b1}} : w_sum[TIME_W-1:0];

   always_ff @(posedge clock) begin
      if (!clr) begin
         r_state       <= IDLE;
         r_presc       <= '0;
         r_white       <= '0;
         r_black       <= '0;
         r_turn        <= 1'b0;
         r_running     <= 1'b0;
         r_flag        <= 1'b0;
         r_flag_player <= 1'b0;
      end else if (bus.load) begin
         r_state   <= IDLE;
         r_presc   <= '0;
         r_white   <= bus.start_time;
         r_black   <= bus.start_time;
         r_turn    <= 1'b0;
         r_running <= 1'b0;
         r_flag    <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_presc <= '0;
                  if (w_active == '0) begin
                     r_state       <= FLAG;
                     r_flag        <= 1'b1;
                     r_flag_player <= r_turn;
                  end else begin
                     r_state   <= RUN;
                     r_running <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (!bus.pause) begin
                  r_presc <= w_tick ? '0 : r_presc + 1'b1;
                  if (w_zero) begin
                     r_state       <= FLAG;
                     r_running     <= 1'b0;
                     r_flag        <= 1'b1;
                     r_flag_player <= r_turn;
                     if (r_turn) r_black <= '0;
                     else        r_white <= '0;
                  end else if (bus.move_done) begin
                     // fractional second of the mover is discarded
                     r_presc <= '0;
                     r_turn  <= ~r_turn;
                     if (r_turn) r_black <= w_sat;
                     else        r_white <= w_sat;
                  end else if (w_tick) begin
                     if (r_turn) r_black <= w_dec;
                     else        r_white <= w_dec;
                  end
               end
            end
            FLAG: begin
               r_state <= FLAG;
            end
            default: begin
               r_state   <= IDLE;
               r_running <= 1'b0;
               r_flag    <= 1'b0;
            end
         endcase
      end
   end

   assign bus.white_time  = r_white;
   assign bus.black_time  = r_black;
   assign bus.turn        = r_turn;
   assign bus.running     = r_running;
   assign bus.flag        = r_flag;
   assign bus.flag_player = r_flag_player;
endmodule
